// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encodings, lights encodings and lamp bit indices for traffic_timed
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_TO_EW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_TO_NS = 3'd5,
        WALK      = 3'd6
    } state_t;

    // lights = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
    localparam int NS_R = 5;
    localparam int NS_Y = 4;
    localparam int NS_G = 3;
    localparam int EW_R = 2;
    localparam int EW_Y = 1;
    localparam int EW_G = 0;

    localparam logic [5:0] LIGHTS_NS_GREEN  = 6'b001_100;
    localparam logic [5:0] LIGHTS_NS_YELLOW = 6'b010_100;
    localparam logic [5:0] LIGHTS_RED_TO_EW = 6'b100_100;
    localparam logic [5:0] LIGHTS_EW_GREEN  = 6'b100_001;
    localparam logic [5:0] LIGHTS_EW_YELLOW = 6'b100_010;
    localparam logic [5:0] LIGHTS_RED_TO_NS = 6'b100_100;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - clear/increment/saturating phase counter with elapsed compare
module phase_timer #(
    parameter int TW  = 6,
    parameter int SAT = 31
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          restart,
    input  logic [TW-1:0] limit,
    output logic [TW-1:0] count,
    output logic          elapsed,
    output logic          saturated
);

    localparam logic [TW-1:0] SAT_V = TW'(SAT);

    always_ff @(posedge clk) begin
        if (clr || restart) begin
            count <= '0;
        end else if (count != SAT_V) begin
            count <= count + TW'(1);
        end
    end

    // limit is always >= 1, so limit-1 cannot underflow
    assign elapsed   = (count >= (limit - TW'(1)));
    assign saturated = (count == SAT_V);

endmodule

// File: rtl/traffic_timed.sv
// rtl/traffic_timed.sv - two-road timed traffic controller; TRAFFIC_PED_EN adds pedestrian WALK phase
module traffic_timed
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 32,
    parameter int YELLOW_T  = 4,
    parameter int CLEAR_T   = 2,
    parameter int TW        = 6
`ifdef TRAFFIC_PED_EN
    ,
    parameter int WALK_T    = 6
`endif
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       nscar,
    input  logic       ewcar,
`ifdef TRAFFIC_PED_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [5:0] lights,
    output logic [2:0] state_o,
    output logic       switch_p
);

    if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || MAX_GREEN >= (1 << TW) ||
        YELLOW_T < 1 || CLEAR_T < 1 || YELLOW_T > MAX_GREEN || CLEAR_T > MAX_GREEN
`ifdef TRAFFIC_PED_EN
        || WALK_T < 1 || WALK_T > MAX_GREEN
`endif
        ) begin : g_bad_params
        $error("traffic_timed: illegal timing parameters");
    end

    state_t        state;
    logic          advance;
    logic [TW-1:0] limit;
    logic [TW-1:0] count;
    logic          elapsed;
    logic          saturated;
    logic          ns_dem;
    logic          ew_dem;

`ifdef TRAFFIC_PED_EN
    logic ped_pend;
    logic walk_to_ew;
    assign ns_dem = nscar | ped_pend;
    assign ew_dem = ewcar | ped_pend;
    assign walk   = (state == WALK);
`else
    assign ns_dem = nscar;
    assign ew_dem = ewcar;
`endif

    phase_timer #(.TW(TW), .SAT(MAX_GREEN - 1)) u_timer (
        .clk       (clk),
        .clr       (clr),
        .restart   (advance),
        .limit     (limit),
        .count     (count),
        .elapsed   (elapsed),
        .saturated (saturated)
    );

    // Own-road demand only delays the yield until the max-green timer saturates
    always_comb begin
        limit   = TW'(MIN_GREEN);
        advance = 1'b0;
        case (state)
            NS_GREEN:  advance = elapsed && ew_dem && (!nscar || saturated);
            EW_GREEN:  advance = elapsed && ns_dem && (!ewcar || saturated);
            NS_YELLOW, EW_YELLOW: begin
                limit   = TW'(YELLOW_T);
                advance = elapsed;
            end
            RED_TO_EW, RED_TO_NS: begin
                limit   = TW'(CLEAR_T);
                advance = elapsed;
            end
`ifdef TRAFFIC_PED_EN
            WALK: begin
                limit   = TW'(WALK_T);
                advance = elapsed;
            end
`endif
            default:   advance = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= NS_GREEN;
            switch_p <= 1'b0;
`ifdef TRAFFIC_PED_EN
            ped_pend   <= 1'b0;
            walk_to_ew <= 1'b0;
`endif
        end else begin
            switch_p <= 1'b0;
`ifdef TRAFFIC_PED_EN
            ped_pend <= ped_pend | ped_req;
`endif
            if (advance) begin
                case (state)
                    NS_GREEN:  state <= NS_YELLOW;
                    NS_YELLOW: state <= RED_TO_EW;
                    RED_TO_EW:
`ifdef TRAFFIC_PED_EN
                        if (ped_pend) begin
                            state      <= WALK;
                            walk_to_ew <= 1'b1;
                            ped_pend   <= ped_req;
                        end else
`endif
                        begin
                            state    <= EW_GREEN;
                            switch_p <= 1'b1;
                        end
                    EW_GREEN:  state <= EW_YELLOW;
                    EW_YELLOW: state <= RED_TO_NS;
                    RED_TO_NS:
`ifdef TRAFFIC_PED_EN
                        if (ped_pend) begin
                            state      <= WALK;
                            walk_to_ew <= 1'b0;
                            ped_pend   <= ped_req;
                        end else
`endif
                        begin
                            state    <= NS_GREEN;
                            switch_p <= 1'b1;
                        end
`ifdef TRAFFIC_PED_EN
                    WALK: begin
                        state    <= walk_to_ew ? EW_GREEN : NS_GREEN;
                        switch_p <= 1'b1;
                    end
`endif
                    default:   state <= NS_GREEN;
                endcase
            end
        end
    end

    always_comb begin
        case (state)
            NS_GREEN:  lights = LIGHTS_NS_GREEN;
            NS_YELLOW: lights = LIGHTS_NS_YELLOW;
            RED_TO_EW: lights = LIGHTS_RED_TO_EW;
            EW_GREEN:  lights = LIGHTS_EW_GREEN;
            EW_YELLOW: lights = LIGHTS_EW_YELLOW;
            default:   lights = LIGHTS_RED_TO_NS;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_traffic_timed.sv
// tb/tb_traffic_timed.sv - scoreboard bench for traffic_timed against a phase/duration reference model
module tb_traffic_timed;

    localparam int MIN_G  = 8;
    localparam int MAX_G  = 32;
    localparam int YEL    = 4;
    localparam int CLR_T  = 2;
    localparam int WALK_D = 6;

    logic       clk   = 1'b0;
    logic       clr   = 1'b1;
    logic       nscar = 1'b0;
    logic       ewcar = 1'b0;
    logic [5:0] lights;
    logic [2:0] state_o;
    logic       switch_p;
`ifdef TRAFFIC_PED_EN
    logic       ped_req = 1'b0;
    logic       walk;
`endif

    always #5 clk = ~clk;

    traffic_timed dut (
        .clk      (clk),
        .clr      (clr),
        .nscar    (nscar),
        .ewcar    (ewcar),
`ifdef TRAFFIC_PED_EN
        .ped_req  (ped_req),
        .walk     (walk),
`endif
        .lights   (lights),
        .state_o  (state_o),
        .switch_p (switch_p)
    );

    typedef struct {
        int         st;
        logic [5:0] lt;
        logic       sw;
        logic       wk;
        int         idx;
    } exp_t;

    exp_t sbq[$];
    int   pulses[$];
    int   errors   = 0;
    int   checks   = 0;
    int   push_idx = 0;
    bit   done     = 0;

    // reference model: phase number, cycles spent in it (unbounded), pedestrian memory
    int m_st  = 0;
    int m_age = 0;
    bit m_pp  = 0;
    bit m_to_ew = 0;

    function automatic logic [5:0] lights_of(input int st);
        logic [2:0] ns;
        logic [2:0] ew;
        ns = (st == 0) ? 3'b001 : (st == 1) ? 3'b010 : 3'b100;
        ew = (st == 3) ? 3'b001 : (st == 4) ? 3'b010 : 3'b100;
        return {ns, ew};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit c, input bit n, input bit e, input bit p);
        bit   adv;
        bit   sw;
        bit   pp_next;
        exp_t x;
        clr   = c;
        nscar = n;
        ewcar = e;
`ifdef TRAFFIC_PED_EN
        ped_req = p;
        pp_next = m_pp | p;
`else
        pp_next = 1'b0;
`endif
        sw = 1'b0;
        if (c) begin
            m_st  = 0;
            m_age = 0;
            m_pp  = 1'b0;
        end else begin
            case (m_st)
                0:       adv = (m_age >= MIN_G - 1) && (e || m_pp) && (!n || m_age >= MAX_G - 1);
                3:       adv = (m_age >= MIN_G - 1) && (n || m_pp) && (!e || m_age >= MAX_G - 1);
                1, 4:    adv = (m_age + 1 == YEL);
                2, 5:    adv = (m_age + 1 == CLR_T);
                default: adv = (m_age + 1 == WALK_D);
            endcase
            if (adv) begin
                case (m_st)
                    0: m_st = 1;
                    1: m_st = 2;
                    3: m_st = 4;
                    4: m_st = 5;
                    2, 5: begin
                        if (m_pp) begin
                            m_to_ew = (m_st == 2);
                            m_st    = 6;
                            pp_next = p;
                        end else begin
                            m_st = (m_st == 2) ? 3 : 0;
                            sw   = 1'b1;
                        end
                    end
                    default: begin
                        m_st = m_to_ew ? 3 : 0;
                        sw   = 1'b1;
                    end
                endcase
                m_age = 0;
            end else begin
                m_age++;
            end
            m_pp = pp_next;
        end
        x.st  = m_st;
        x.lt  = lights_of(m_st);
        x.sw  = sw;
        x.wk  = (m_st == 6);
        x.idx = push_idx;
        sbq.push_back(x);
        push_idx++;
        @(negedge clk);
    endtask

    task automatic run(input bit c, input bit n, input bit e, input int cnt);
        for (int i = 0; i < cnt; i++) step(c, n, e, 1'b0);
    endtask

    // monitor: one output sample per clock, compared against the oldest expectation
    initial begin
        exp_t x;
        while (1) begin
            @(posedge clk);
            #1;
            if (done) break;
            if (sbq.size() == 0) begin
                chk("scoreboard_underflow", 1, 0);
            end else begin
                x = sbq.pop_front();
                chk("state_o", int'(state_o), x.st);
                chk("lights", int'(lights), int'(x.lt));
                chk("switch_p", int'(switch_p), int'(x.sw));
`ifdef TRAFFIC_PED_EN
                chk("walk", int'(walk), int'(x.wk));
`endif
                chk("both_roads_open", int'(!lights[5] && !lights[2]), 0);
                if (switch_p) pulses.push_back(x.idx);
            end
        end
    end

    initial begin
        int r;
        bit n;
        bit e;
        int len;

        // reset then EW demand only: EW green after 8+4+2, held
        run(1, 0, 0, 2);
        pulses.delete();
        r = push_idx;
        run(0, 0, 1, 40);
        chk("t1_pulse_count", pulses.size(), 1);
        if (pulses.size() >= 1) chk("t1_pulse_at", pulses[0] - r, MIN_G + YEL + CLR_T - 1);

        // both roads busy: max-green alternation, 76-cycle period
        run(1, 1, 1, 2);
        pulses.delete();
        r = push_idx;
        run(0, 1, 1, 160);
        chk("t2_pulse_count", pulses.size(), 4);
        if (pulses.size() == 4) begin
            chk("t2_first_ew", pulses[0] - r, MAX_G + YEL + CLR_T - 1);
            chk("t2_half_period", pulses[1] - pulses[0], MAX_G + YEL + CLR_T);
            chk("t2_period", pulses[2] - pulses[0], 2 * (MAX_G + YEL + CLR_T));
            chk("t2_period_b", pulses[3] - pulses[1], 76);
        end

        // no demand: NS green forever, no switch
        run(1, 0, 0, 2);
        pulses.delete();
        run(0, 0, 0, 200);
        chk("t3_no_pulse", pulses.size(), 0);
        chk("t3_lights", int'(lights), int'(6'b001_100));

        // short cross pulse before min-green, then contested green runs to max
        run(1, 1, 0, 2);
        pulses.delete();
        run(0, 1, 0, 3);
        run(0, 1, 1, 2);
        run(0, 1, 0, 5);
        chk("t4_no_early_switch", int'(state_o), 0);
        run(0, 1, 1, 21);
        chk("t4_still_green_at_30", int'(state_o), 0);
        run(0, 1, 1, 1);
        chk("t4_yellow_after_31", int'(state_o), 1);
        run(0, 1, 1, 6);

        // clr in EW yellow
        run(1, 0, 0, 2);
        run(0, 0, 1, MIN_G + YEL + CLR_T);
        run(0, 1, 0, MIN_G + 1);
        chk("t5_in_ew_yellow", int'(state_o), 4);
        run(1, 1, 0, 1);
        chk("t5_clr_state", int'(state_o), 0);
        chk("t5_clr_switch", int'(switch_p), 0);
        run(0, 0, 0, 4);

`ifdef TRAFFIC_PED_EN
        run(1, 0, 0, 2);
        pulses.delete();
        r = push_idx;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        run(0, 0, 0, MIN_G + YEL + CLR_T + WALK_D + 3);
        chk("t6_pulse_count", pulses.size(), 1);
        if (pulses.size() >= 1) chk("t6_pulse_at", pulses[0] - r, MIN_G + YEL + CLR_T + WALK_D - 1);
`endif

        // randomized sensor segments with occasional clr and pedestrian requests
        for (int s = 0; s < 60; s++) begin
            n   = 1'($urandom_range(0, 1));
            e   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 60);
            for (int k = 0; k < len; k++)
                step($urandom_range(0, 299) == 0, n, e, $urandom_range(0, 49) == 0);
        end

        done = 1;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
